// File: rtl/tl_a_buffer_if.sv
// TileLink Channel A beat bundle with valid/ready handshake.
// master drives fields+valid, slave returns ready.
interface tl_a_buffer_if #(
  parameter int SIZE_WD   = 3,
  parameter int ADDR_WD   = 36,
  parameter int DATA_WD   = 256,
  parameter int SOURCE_WD = 32,
  parameter int USER_WD   = 32,
  parameter int ECHO_WD   = 32
) ();
  localparam int MASK_WD = DATA_WD / 8;

  logic [2:0]           opcode;
  logic [2:0]           param;
  logic [SIZE_WD-1:0]   size;
  logic [SOURCE_WD-1:0] source;
  logic [ADDR_WD-1:0]   address;
  logic [USER_WD-1:0]   user;
  logic [ECHO_WD-1:0]   echo;
  logic [MASK_WD-1:0]   mask;
  logic [DATA_WD-1:0]   data;
  logic                 corrupt;
  logic                 valid;
  logic                 ready;

  modport master (
    output opcode, param, size, source, address,
    output user, echo, mask, data, corrupt, valid,
    input  ready
  );

  modport slave (
    input  opcode, param, size, source, address,
    input  user, echo, mask, data, corrupt, valid,
    output ready
  );
endinterface

// File: rtl/tl_a_buffer.sv
// DEPTH-entry FIFO for one TileLink Channel A link.
// Ports: clock/reset (sync, active-high), enq_* upstream beat with
// enq_valid/enq_ready, deq_* head beat with deq_valid/deq_ready,
// count = occupancy. Macro TL_A_BUFFER_FLOW_EN enables zero-latency
// flow-through when the buffer is empty.
module tl_a_buffer #(
  parameter  int SIZE_WD   = 3,
  parameter  int ADDR_WD   = 36,
  parameter  int DATA_WD   = 256,
  parameter  int SOURCE_WD = 32,
  parameter  int USER_WD   = 32,
  parameter  int ECHO_WD   = 32,
  parameter  int DEPTH     = 4,
  localparam int MASK_WD   = DATA_WD / 8,
  localparam int CNT_WD    = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           enq_opcode,
  input  logic [2:0]           enq_param,
  input  logic [SIZE_WD-1:0]   enq_size,
  input  logic [SOURCE_WD-1:0] enq_source,
  input  logic [ADDR_WD-1:0]   enq_address,
  input  logic [USER_WD-1:0]   enq_user,
  input  logic [ECHO_WD-1:0]   enq_echo,
  input  logic [MASK_WD-1:0]   enq_mask,
  input  logic [DATA_WD-1:0]   enq_data,
  input  logic                 enq_corrupt,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  output logic [2:0]           deq_opcode,
  output logic [2:0]           deq_param,
  output logic [SIZE_WD-1:0]   deq_size,
  output logic [SOURCE_WD-1:0] deq_source,
  output logic [ADDR_WD-1:0]   deq_address,
  output logic [USER_WD-1:0]   deq_user,
  output logic [ECHO_WD-1:0]   deq_echo,
  output logic [MASK_WD-1:0]   deq_mask,
  output logic [DATA_WD-1:0]   deq_data,
  output logic                 deq_corrupt,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [CNT_WD-1:0]    count
);
  localparam int PTR_WD = $clog2(DEPTH);
  localparam int W = 6 + SIZE_WD + SOURCE_WD + ADDR_WD
                   + USER_WD + ECHO_WD + MASK_WD + DATA_WD + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tl_a_buffer: DEPTH must be a power of 2 and >= 2");
  end

  typedef logic [W-1:0] beat_t;

  beat_t             mem_q [DEPTH];
  beat_t             mem_d [DEPTH];
  logic [PTR_WD-1:0] wptr_q, wptr_d;
  logic [PTR_WD-1:0] rptr_q, rptr_d;
  logic [CNT_WD-1:0] count_q, count_d;

  beat_t enq_bus, deq_bus, head;
  logic  full, empty;
  logic  enq_fire, deq_fire;
  logic  bypass, wr_en, rd_en;

  assign enq_bus = {enq_opcode, enq_param, enq_size,
                    enq_source, enq_address, enq_user,
                    enq_echo, enq_mask, enq_data,
                    enq_corrupt};

  assign {deq_opcode, deq_param, deq_size,
          deq_source, deq_address, deq_user,
          deq_echo, deq_mask, deq_data,
          deq_corrupt} = deq_bus;

  assign count = count_q;

  always_comb begin
    full      = (count_q == CNT_WD'(DEPTH));
    empty     = (count_q == '0);
    enq_ready = !full && !reset;
    head      = mem_q[rptr_q];
`ifdef TL_A_BUFFER_FLOW_EN
    // Empty: present the incoming beat directly.
    deq_valid = !empty || enq_valid;
    deq_bus   = (empty && enq_valid) ? enq_bus : head;
`else
    deq_valid = !empty;
    deq_bus   = head;
`endif
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
`ifdef TL_A_BUFFER_FLOW_EN
    // Beat consumed in flight never touches storage.
    bypass    = empty && enq_fire && deq_ready;
`else
    bypass    = 1'b0;
`endif
    wr_en     = enq_fire && !bypass;
    rd_en     = deq_fire && !bypass;

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[wptr_q] = enq_bus;
      wptr_d        = wptr_q + PTR_WD'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + PTR_WD'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_WD'(1);
      2'b01:   count_d = count_q - CNT_WD'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  a_count_range: assert property (
    @(posedge clock) disable iff (reset)
    count_q <= CNT_WD'(DEPTH)
  ) else $error("tl_a_buffer: count above DEPTH");

  a_head_stable: assert property (
    @(posedge clock) disable iff (reset)
    (deq_valid && !deq_ready) |=> $stable(deq_bus)
  ) else $error("tl_a_buffer: head changed while stalled");
endmodule
